arb_byte_packer: RTL
====================

# arb_byte_packer

- Sits directly downstream of the round-robin arbiter and consumes its `dout`/`valid` byte stream.
- Packs the accepted bytes into 32-bit words, tagging each word with a byte-keep mask.
- Buffers completed words in a small output queue and presents them to the next stage over a valid/ready handshake.
- Drops words on queue overflow and records the event in a sticky flag.

## Interface
Parameters:
- `OUT_DEPTH`, default 4: output queue depth in words. Must be a power of two, ≥ 2.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset. **Asynchronous, active-high.**
- `din` in 8: byte from the arbiter (`dout`).
- `din_valid` in 1: `din` is valid this cycle (arbiter `valid`); no backpressure upstream.
- `flush` in 1: close the partial word being assembled this cycle.
- `out_ready` in 1: downstream accepts the head word this cycle.
- `word_out` out 32: head-of-queue word; byte 0 in [7:0].
- `word_keep` out 4: head-of-queue byte mask; bit i = byte i valid.
- `word_valid` out 1: queue non-empty.
- `fill` out 3: bytes currently held in the assembly register (0..3).
- `overflow` out 1: sticky; set when a word is dropped because the queue is full.
- `clr_ovf` in 1: synchronous clear of `overflow`.

## Operation
**Assembly register**
- Holds 32 bits plus a byte pointer `ptr` (0..3); `fill` = `ptr`.
- On `din_valid`: `din` is written into lane `ptr`, and `ptr` increments mod 4.

**Word completion**
- A word is complete when:
  - a byte is written with `ptr`==3, giving keep 4'b1111; or
  - `flush` is high with at least one byte held, counting a byte written the same cycle.
- For a flushed word, keep = lanes 0..n-1 set, n = bytes held. Unused lanes are 0.
- After completion, `ptr` = 0 and the assembly data clears to 0.
- `flush` with no bytes held and no `din_valid` does nothing.
- `flush` together with `din_valid` at `ptr`==3 produces exactly one full word, not a second empty one.

**Output queue**
- Circular buffer of `OUT_DEPTH` entries (data + keep), with read pointer, write pointer and count.
- Pop when `word_valid && out_ready`.
- Push when a word completes and either count < `OUT_DEPTH` or a pop happens the same cycle (full with simultaneous pop is accepted).
- Otherwise the completed word is discarded, `overflow` is set, and assembly continues normally with the next byte.
- Pointers wrap mod `OUT_DEPTH`.

**Overflow flag**
- `overflow` stays set until `clr_ovf` or `rst`.
- If a drop and `clr_ovf` occur in the same cycle, set wins.

## Timing
**Reset values (`rst` high, asynchronous)**
- `word_out`=0, `word_keep`=0, `word_valid`=0, `fill`=0, `overflow`=0.
- All pointers and counts = 0; queue contents are don't-care.
- Reset mid-word or with a non-empty queue discards everything.
- Deassertion is sampled on the next rising edge.

**Latency**
- A byte accepted at edge N is reflected in `fill` after edge N.
- If the completing byte (or `flush`) arrives at edge N and the queue was empty, `word_valid`=1 with that word on `word_out`/`word_keep` after edge N. Input-to-output latency is one cycle.

**Queue outputs**
- `word_out`, `word_keep` and `word_valid` are driven from registered queue state with no combinational path from `din`, `din_valid` or `flush`.
- `word_valid` depends only on count.
- `word_out` and `word_keep` hold stable while `word_valid && !out_ready`.

**Throughput**
- One byte per cycle in; one word per cycle out.
- Sustained byte input can never overflow if `out_ready` is high at least once every 4 cycles.

**Simultaneous events**
- Push and pop in one cycle leave count unchanged.
- A pop on an empty queue is ignored.

## Test plan
- **Full word:** reset, then bytes 0x11, 0x22, 0x33, 0x44 on consecutive cycles with `out_ready`=0 → `word_valid`=1 one cycle after 0x44, `word_out`=0x44332211, `word_keep`=4'hF, `fill`=0.
- **Partial flush:** bytes 0xAA, 0xBB, then `flush` alone → `word_out`=0x0000BBAA, keep 4'b0011. Then `flush` alone again → no new word, count unchanged.
- **Flush with byte:** `flush` with `din_valid`, `din`=0x5A, `fill`=0 → word 0x0000005A, keep 4'b0001. Then `flush` with the 4th byte → exactly one full word.
- **Overflow:** `OUT_DEPTH`=4, `out_ready`=0, 5 full words → queue holds words 1–4 and `overflow`=1. Pop one, then `clr_ovf` → head is word 2, `overflow`=0. Full queue with push and pop in the same cycle → no drop, `overflow` stays 0.
- **Wrap-around:** 20 words streamed with `out_ready` toggling 1,0,1,0 → words emerge in order with correct data, no loss, `overflow`=0.
- **Async reset mid-operation:** assert `rst` asynchronously between edges with `fill`=2 and 3 words queued → all outputs 0 immediately. After release, the next 4 bytes form a fresh word with keep 4'hF.

Source files
------------

// File: rtl/arb_byte_packer.sv
// Packs the arbiter's byte stream into 32-bit words with a byte-keep mask and
// buffers finished words in a small circular queue behind a valid/ready port.
module arb_byte_packer #(
  parameter int OUT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din,
  input  logic        din_valid,
  input  logic        flush,
  input  logic        out_ready,
  input  logic        clr_ovf,
  output logic [31:0] word_out,
  output logic [3:0]  word_keep,
  output logic        word_valid,
  output logic [2:0]  fill,
  output logic        overflow
);

  localparam int AW = $clog2(OUT_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(OUT_DEPTH);

  logic [31:0]   asm_q, asm_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [31:0]   mem_data_q [OUT_DEPTH];
  logic [31:0]   mem_data_d [OUT_DEPTH];
  logic [3:0]    mem_keep_q [OUT_DEPTH];
  logic [3:0]    mem_keep_d [OUT_DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic [2:0]    held;
  logic [31:0]   new_word;
  logic [3:0]    new_keep;
  logic          complete, pop, push, drop;

  // held counts the byte landing this cycle, so a flush alongside the fourth
  // byte closes one full word instead of also emitting an empty one.
  always_comb begin
    held     = {1'b0, ptr_q} + {2'b00, din_valid};
    new_word = asm_q;
    if (din_valid) new_word[{ptr_q, 3'b000} +: 8] = din;
    complete = (held == 3'd4) || (flush && held != 3'd0);
    case (held)
      3'd1:    new_keep = 4'b0001;
      3'd2:    new_keep = 4'b0011;
      3'd3:    new_keep = 4'b0111;
      default: new_keep = 4'b1111;
    endcase
    pop  = (cnt_q != '0) && out_ready;
    push = complete && ((cnt_q != DEPTH) || pop);
    drop = complete && !push;
  end

  always_comb begin
    asm_d      = asm_q;
    ptr_d      = ptr_q;
    mem_data_d = mem_data_q;
    mem_keep_d = mem_keep_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;

    if (complete) begin
      asm_d = '0;
      ptr_d = '0;
    end else if (din_valid) begin
      asm_d = new_word;
      ptr_d = ptr_q + 2'd1;
    end

    if (push) begin
      mem_data_d[wr_q] = new_word;
      mem_keep_d[wr_q] = new_keep;
      wr_d             = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;

    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;

    // A drop in the same cycle as a clear must leave the flag set.
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q <= '0;
      ptr_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_keep_q[i] <= '0;
      end
    end else begin
      asm_q      <= asm_d;
      ptr_q      <= ptr_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      mem_data_q <= mem_data_d;
      mem_keep_q <= mem_keep_d;
    end
  end

  // Outputs come only from registered queue state; an empty queue reads as zero.
  assign word_valid = (cnt_q != '0);
  assign word_out   = word_valid ? mem_data_q[rd_q] : 32'h0;
  assign word_keep  = word_valid ? mem_keep_q[rd_q] : 4'h0;
  assign fill       = {1'b0, ptr_q};
  assign overflow   = ovf_q;

endmodule
